// File: rtl/sync_event_arbiter_if.sv
// Event arbiter bus interface.
//   Bundles the request/handshake/status signals between the event sources plus
//   consumer (master side) and the arbiter (slave side).
//   async_req    master -> slave  asynchronous request lines, rising edge = event
//   evt_ready    master -> slave  consumer accepts the offered event this cycle
//   clr_overrun  master -> slave  single-cycle strobe clearing all sticky overrun bits
//   evt_valid    slave -> master  event offered to the consumer
//   evt_ch       slave -> master  channel index of the offered event
//   pending      slave -> master  per-channel event waiting for grant
//   overrun      slave -> master  sticky per-channel coalescing flag
interface sync_event_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] async_req;
  logic              evt_ready;
  logic              clr_overrun;
  logic              evt_valid;
  logic [CH_W-1:0]   evt_ch;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;

  modport master (
    output async_req, evt_ready, clr_overrun,
    input  evt_valid, evt_ch, pending, overrun
  );

  modport slave (
    input  async_req, evt_ready, clr_overrun,
    output evt_valid, evt_ch, pending, overrun
  );
endinterface

// File: rtl/sync_event_arbiter.sv
// sync_event_arbiter
//   Brings NUM_CH asynchronous request lines into the clk domain, turns each rising
//   edge into a latched pending event and hands the events one at a time to a single
//   consumer, choosing between channels round-robin, over a valid/ready handshake.
// Ports:
//   clk    system clock, everything on posedge
//   n_rst  synchronous active-low reset
//   bus    sync_event_arbiter_if.slave: async_req, evt_ready, clr_overrun in;
//          evt_valid, evt_ch, pending, overrun out
module sync_event_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sync_event_arbiter_if.slave  bus
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] chain_out;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] rise;

  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] pending_n;
  logic [NUM_CH-1:0] overrun_q;
  logic [NUM_CH-1:0] overrun_n;
  logic [NUM_CH-1:0] load_mask;

  logic [CH_W-1:0]   last_grant_q;
  logic [CH_W-1:0]   win_ch;
  logic [CH_W-1:0]   idx_c;
  logic              win_found;
  logic              load;

  state_t            state_q;
  logic              evt_valid_q;
  logic [CH_W-1:0]   evt_ch_q;

  // ---- Stage: synchronizer chain and edge history ----
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus.async_req;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= chain_out;
    end
  end

  assign chain_out = sync_q[SYNC_STAGES-1];
  // prev resets to 0, so a line already high at reset release yields one event.
  assign rise      = chain_out & ~prev_q;

  // ---- Stage: round-robin winner from the registered pending vector ----
  // Same-cycle rises are not visible here; they only reach pending next edge.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    idx_c     = '0;
    for (int o = 1; o <= NUM_CH; o++) begin
      idx_c = CH_W'((int'(last_grant_q) + o) % NUM_CH);
      if (!win_found && pending_q[idx_c]) begin
        win_found = 1'b1;
        win_ch    = idx_c;
      end
    end
  end

  // A new event is loaded from IDLE, or in OFFER when the current one transfers.
  assign load = win_found && ((state_q == IDLE) || bus.evt_ready);

  // ---- Stage: pending / overrun bookkeeping ----
  always_comb begin
    load_mask = '0;
    if (load) begin
      load_mask[win_ch] = 1'b1;
    end
    // A rise on the channel being loaded is a fresh event, not a coalesced one.
    pending_n = rise | (pending_q & ~load_mask);
    // Set has priority over the clear strobe.
    overrun_n = (rise & pending_q & ~load_mask)
              | (overrun_q & ~{NUM_CH{bus.clr_overrun}});
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= pending_n;
      overrun_q <= overrun_n;
    end
  end

  // ---- Stage: offer FSM with registered handshake outputs ----
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            evt_ch_q     <= win_ch;
            last_grant_q <= win_ch;
            evt_valid_q  <= 1'b1;
            state_q      <= OFFER;
          end
        end
        OFFER: begin
          // evt_valid/evt_ch hold while the consumer stalls.
          if (bus.evt_ready) begin
            if (load) begin
              evt_ch_q     <= win_ch;
              last_grant_q <= win_ch;
            end else begin
              evt_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_ch    = evt_ch_q;
  assign bus.pending   = pending_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Directed testbench for sync_event_arbiter (NUM_CH=4, SYNC_STAGES=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sync_event_arbiter;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  sync_event_arbiter_if #(.NUM_CH(4)) bus ();

  sync_event_arbiter #(
    .NUM_CH      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Full view {valid, ch, pending, overrun} and idle view {valid, pending, overrun}.
  wire [10:0] obs      = {bus.evt_valid, bus.evt_ch, bus.pending, bus.overrun};
  wire [8:0]  obs_idle = {bus.evt_valid, bus.pending, bus.overrun};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.async_req   = 4'b0000;
    bus.evt_ready   = 1'b0;
    bus.clr_overrun = 1'b0;
    n_rst = 1'b0;
    tick();
    tick();
    n_tests++;
    if (obs !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", obs, 11'b0);
    end
    n_rst = 1'b1;
    tick(); tick(); tick();
    n_tests++;
    if (obs !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_release_quiet: got %b expected %b", obs, 11'b0);
    end
  endtask

  task automatic test_single_latency();
    bus.evt_ready = 1'b1;
    bus.async_req = 4'b0000;
    apply_reset();
    bus.async_req = 4'b0100;   // sampled at posedge k
    tick();                    // after k
    bus.async_req = 4'b0000;
    n_tests++;
    if (obs_idle !== 9'b0) begin
      n_fail++; $display("FAIL lat_k0: got %b expected %b", obs_idle, 9'b0);
    end
    tick();                    // after k+1
    n_tests++;
    if (obs_idle !== 9'b0) begin
      n_fail++; $display("FAIL lat_k1: got %b expected %b", obs_idle, 9'b0);
    end
    tick();                    // after k+2: pending set
    n_tests++;
    if (obs_idle !== {1'b0, 4'b0100, 4'b0000}) begin
      n_fail++; $display("FAIL lat_k2_pending: got %b expected %b", obs_idle, {1'b0, 4'b0100, 4'b0000});
    end
    tick();                    // after k+3: offered
    n_tests++;
    if (obs !== {1'b1, 2'd2, 4'b0000, 4'b0000}) begin
      n_fail++; $display("FAIL lat_k3_offer: got %b expected %b", obs, {1'b1, 2'd2, 4'b0000, 4'b0000});
    end
    tick();                    // after k+4: consumed
    n_tests++;
    if (obs_idle !== 9'b0) begin
      n_fail++; $display("FAIL lat_k4_done: got %b expected %b", obs_idle, 9'b0);
    end
  endtask

  task automatic test_back_to_back();
    bus.evt_ready = 1'b1;
    bus.async_req = 4'b0000;
    apply_reset();
    bus.async_req = 4'b1011;
    tick(); tick(); tick();    // after k+2
    n_tests++;
    if (obs_idle !== {1'b0, 4'b1011, 4'b0000}) begin
      n_fail++; $display("FAIL b2b_pending: got %b expected %b", obs_idle, {1'b0, 4'b1011, 4'b0000});
    end
    tick();
    n_tests++;
    if (obs !== {1'b1, 2'd0, 4'b1010, 4'b0000}) begin
      n_fail++; $display("FAIL b2b_ch0: got %b expected %b", obs, {1'b1, 2'd0, 4'b1010, 4'b0000});
    end
    tick();
    n_tests++;
    if (obs !== {1'b1, 2'd1, 4'b1000, 4'b0000}) begin
      n_fail++; $display("FAIL b2b_ch1: got %b expected %b", obs, {1'b1, 2'd1, 4'b1000, 4'b0000});
    end
    tick();
    n_tests++;
    if (obs !== {1'b1, 2'd3, 4'b0000, 4'b0000}) begin
      n_fail++; $display("FAIL b2b_ch3: got %b expected %b", obs, {1'b1, 2'd3, 4'b0000, 4'b0000});
    end
    tick();
    n_tests++;
    if (obs_idle !== 9'b0) begin
      n_fail++; $display("FAIL b2b_idle: got %b expected %b", obs_idle, 9'b0);
    end
    bus.async_req = 4'b0000;
  endtask

  task automatic test_stall_rr();
    bus.evt_ready = 1'b0;
    bus.async_req = 4'b0000;
    apply_reset();
    bus.async_req = 4'b0010;
    tick(); tick(); tick(); tick();   // after k+3
    n_tests++;
    if (obs !== {1'b1, 2'd1, 4'b0000, 4'b0000}) begin
      n_fail++; $display("FAIL stall_first: got %b expected %b", obs, {1'b1, 2'd1, 4'b0000, 4'b0000});
    end
    bus.async_req = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if ({bus.evt_valid, bus.evt_ch} !== 3'b101) begin
        n_fail++; $display("FAIL stall_hold%0d: got %b expected %b", i, {bus.evt_valid, bus.evt_ch}, 3'b101);
      end
    end
    n_tests++;
    if (bus.pending !== 4'b0101) begin
      n_fail++; $display("FAIL stall_pending: got %b expected %b", bus.pending, 4'b0101);
    end
    bus.evt_ready = 1'b1;
    tick();
    n_tests++;
    if (obs !== {1'b1, 2'd2, 4'b0001, 4'b0000}) begin
      n_fail++; $display("FAIL rr_ch2: got %b expected %b", obs, {1'b1, 2'd2, 4'b0001, 4'b0000});
    end
    tick();
    n_tests++;
    if (obs !== {1'b1, 2'd0, 4'b0000, 4'b0000}) begin
      n_fail++; $display("FAIL rr_ch0: got %b expected %b", obs, {1'b1, 2'd0, 4'b0000, 4'b0000});
    end
    tick();
    n_tests++;
    if (obs_idle !== 9'b0) begin
      n_fail++; $display("FAIL rr_idle: got %b expected %b", obs_idle, 9'b0);
    end
    bus.async_req = 4'b0000;
  endtask

  task automatic test_overrun();
    int c3;
    int cv;
    bus.evt_ready = 1'b0;
    bus.async_req = 4'b0000;
    apply_reset();
    bus.async_req = 4'b0001;
    tick(); tick(); tick(); tick();   // ch0 offered and stalled
    for (int p = 0; p < 2; p++) begin
      bus.async_req = 4'b1001;
      tick();
      bus.async_req = 4'b0001;
      tick();
    end
    tick(); tick();
    n_tests++;
    if (obs !== {1'b1, 2'd0, 4'b1000, 4'b1000}) begin
      n_fail++; $display("FAIL ovr_set: got %b expected %b", obs, {1'b1, 2'd0, 4'b1000, 4'b1000});
    end
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    n_tests++;
    if (obs !== {1'b1, 2'd0, 4'b1000, 4'b0000}) begin
      n_fail++; $display("FAIL ovr_clear: got %b expected %b", obs, {1'b1, 2'd0, 4'b1000, 4'b0000});
    end
    bus.async_req = 4'b1001;          // third edge, sampled at m
    tick();
    bus.async_req = 4'b0001;
    tick();                           // after m+1
    n_tests++;
    if (bus.overrun !== 4'b0000) begin
      n_fail++; $display("FAIL ovr_not_yet: got %b expected %b", bus.overrun, 4'b0000);
    end
    bus.clr_overrun = 1'b1;           // lands on the same edge as the new set
    tick();
    bus.clr_overrun = 1'b0;
    n_tests++;
    if (obs !== {1'b1, 2'd0, 4'b1000, 4'b1000}) begin
      n_fail++; $display("FAIL ovr_set_beats_clr: got %b expected %b", obs, {1'b1, 2'd0, 4'b1000, 4'b1000});
    end
    bus.evt_ready = 1'b1;
    c3 = 0;
    cv = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.evt_valid === 1'b1) begin
        cv++;
        if (bus.evt_ch === 2'd3) c3++;
      end
    end
    n_tests++;
    if (c3 !== 1 || cv !== 1) begin
      n_fail++; $display("FAIL ovr_single_ch3: got ch3=%0d valid=%0d expected ch3=1 valid=1", c3, cv);
    end
    n_tests++;
    if (obs_idle !== {1'b0, 4'b0000, 4'b1000}) begin
      n_fail++; $display("FAIL ovr_sticky: got %b expected %b", obs_idle, {1'b0, 4'b0000, 4'b1000});
    end
    bus.async_req = 4'b0000;
  endtask

  task automatic test_reset_edges();
    int c1;
    int cv;
    bus.evt_ready = 1'b1;
    bus.async_req = 4'b0010;          // held high through reset release
    apply_reset();
    c1 = 0;
    cv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.evt_valid === 1'b1) begin
        cv++;
        if (bus.evt_ch === 2'd1) c1++;
      end
    end
    n_tests++;
    if (c1 !== 1 || cv !== 1) begin
      n_fail++; $display("FAIL rel_high_one_evt: got ch1=%0d valid=%0d expected ch1=1 valid=1", c1, cv);
    end
    bus.evt_ready = 1'b0;
    bus.async_req = 4'b1110;
    tick();
    bus.async_req = 4'b0000;
    tick(); tick(); tick();
    n_tests++;
    if (obs !== {1'b1, 2'd2, 4'b1000, 4'b0000}) begin
      n_fail++; $display("FAIL mid_offer_before: got %b expected %b", obs, {1'b1, 2'd2, 4'b1000, 4'b0000});
    end
    n_rst = 1'b0;
    tick();
    n_tests++;
    if (obs !== 11'b0) begin
      n_fail++; $display("FAIL mid_offer_reset: got %b expected %b", obs, 11'b0);
    end
    n_rst = 1'b1;
    bus.evt_ready = 1'b1;
    bus.async_req = 4'b1001;
    tick(); tick(); tick();
    n_tests++;
    if (obs_idle !== {1'b0, 4'b1001, 4'b0000}) begin
      n_fail++; $display("FAIL post_rst_pending: got %b expected %b", obs_idle, {1'b0, 4'b1001, 4'b0000});
    end
    tick();
    n_tests++;
    if (obs !== {1'b1, 2'd0, 4'b1000, 4'b0000}) begin
      n_fail++; $display("FAIL post_rst_ch0_first: got %b expected %b", obs, {1'b1, 2'd0, 4'b1000, 4'b0000});
    end
    tick();
    n_tests++;
    if (obs !== {1'b1, 2'd3, 4'b0000, 4'b0000}) begin
      n_fail++; $display("FAIL post_rst_ch3: got %b expected %b", obs, {1'b1, 2'd3, 4'b0000, 4'b0000});
    end
    tick();
    n_tests++;
    if (obs_idle !== 9'b0) begin
      n_fail++; $display("FAIL post_rst_idle: got %b expected %b", obs_idle, 9'b0);
    end
    bus.async_req = 4'b0000;
  endtask

  initial begin
    bus.async_req   = 4'b0000;
    bus.evt_ready   = 1'b0;
    bus.clr_overrun = 1'b0;
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_stall_rr();
    test_overrun();
    test_reset_edges();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
